// File: rtl/meter_peak_accum_if.sv
// Bus bundle for meter_peak_accum: aux update strobe, host read handshake and status.
// The DUT connects through the slave modport; the aux/host side uses master.
interface meter_peak_accum_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 8
);
    logic                  aux_en;
    logic [ADDR_WIDTH-1:0] aux_addr;
    logic [DATA_WIDTH-1:0] aux_data;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_clear;
    logic                  rd_ack;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    modport master (
        output aux_en, aux_addr, aux_data, rd_req, rd_addr, rd_clear,
        input  rd_ack, rd_valid, rd_data, busy
    );

    modport slave (
        input  aux_en, aux_addr, aux_data, rd_req, rd_addr, rd_clear,
        output rd_ack, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/meter_peak_accum.sv
// Per-address peak-magnitude table with a single read-modify-write pipe and forwarding.
// Build option METER_DECAY_EN: updates decay the stored peak by old>>DECAY_SHIFT before the max.
module meter_peak_accum #(
    parameter int DATA_WIDTH  = 36,
    parameter int ADDR_WIDTH  = 8,
    parameter int DECAY_SHIFT = 10
) (
    input  logic                clk_i,
    input  logic                reset_i,
    meter_peak_accum_if.slave   bus_if
);
    localparam logic [DATA_WIDTH-1:0] MAG_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};

    if (DECAY_SHIFT < 0 || DECAY_SHIFT >= DATA_WIDTH) begin : g_bad_decay_shift
        $error("meter_peak_accum: DECAY_SHIFT out of range");
    end

    function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (v[DATA_WIDTH-1] == 1'b0) begin
            r = v;
        end else if (v == MOST_NEG) begin
            r = MAG_MAX;
        end else begin
            r = ~v + ONE;
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] peak_update(input logic [DATA_WIDTH-1:0] old_v,
                                                          input logic [DATA_WIDTH-1:0] mag_v);
        logic [DATA_WIDTH-1:0] base;
`ifdef METER_DECAY_EN
        base = old_v - (old_v >> DECAY_SHIFT);
`else
        base = old_v;
`endif
        return (mag_v > base) ? mag_v : base;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] mem_rdata_q;

    logic                  busy_q,       busy_d;
    logic [ADDR_WIDTH-1:0] sweep_addr_q, sweep_addr_d;
    logic                  s1_valid_q,   s1_valid_d;
    logic                  s1_rd_q,      s1_rd_d;
    logic                  s1_clear_q,   s1_clear_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q,    s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_mag_q,     s1_mag_d;
    logic                  wb_valid_q,   wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q,    wb_addr_d;
    logic [DATA_WIDTH-1:0] wb_data_q,    wb_data_d;
    logic                  rd_valid_q,   rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,    rd_data_d;

    logic                  acc_upd_s;
    logic                  acc_rd_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic [DATA_WIDTH-1:0] old_s;
    logic                  pipe_we_s;
    logic [DATA_WIDTH-1:0] pipe_wdata_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    // Arbitration, forwarding and next-state for the pipe and the init sweep
    always_comb begin
        acc_upd_s  = bus_if.aux_en & ~busy_q & ~reset_i;
        acc_rd_s   = bus_if.rd_req & ~bus_if.aux_en & ~busy_q & ~reset_i;
        acc_addr_s = bus_if.aux_en ? bus_if.aux_addr : bus_if.rd_addr;

        // The op one ahead writes on the same edge this op's RAM read happens, so bypass it
        if (wb_valid_q && (wb_addr_q == s1_addr_q)) begin
            old_s = wb_data_q;
        end else begin
            old_s = mem_rdata_q;
        end

        pipe_we_s    = s1_valid_q & (~s1_rd_q | s1_clear_q) & ~reset_i;
        pipe_wdata_s = s1_rd_q ? ZERO : peak_update(old_s, s1_mag_q);

        if (busy_q) begin
            mem_we_s    = ~reset_i;
            mem_waddr_s = sweep_addr_q;
            mem_wdata_s = ZERO;
        end else begin
            mem_we_s    = pipe_we_s;
            mem_waddr_s = s1_addr_q;
            mem_wdata_s = pipe_wdata_s;
        end

        if (busy_q) begin
            sweep_addr_d = sweep_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            busy_d       = (sweep_addr_q != {ADDR_WIDTH{1'b1}});
        end else begin
            sweep_addr_d = sweep_addr_q;
            busy_d       = 1'b0;
        end

        s1_valid_d = acc_upd_s | acc_rd_s;
        s1_rd_d    = acc_rd_s;
        s1_clear_d = bus_if.rd_clear;
        s1_addr_d  = acc_addr_s;
        s1_mag_d   = sat_abs(bus_if.aux_data);

        wb_valid_d = pipe_we_s;
        wb_addr_d  = s1_addr_q;
        wb_data_d  = pipe_wdata_s;

        rd_valid_d = s1_valid_q & s1_rd_q;
        if (s1_valid_q && s1_rd_q) begin
            rd_data_d = old_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Table storage: one write port (sweep or pipe), registered read for the accepted op
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
        mem_rdata_q <= mem_q[acc_addr_s];
    end

    // Control and output registers; reset flushes the pipe and restarts the sweep
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q       <= 1'b1;
            sweep_addr_q <= {ADDR_WIDTH{1'b0}};
            s1_valid_q   <= 1'b0;
            s1_rd_q      <= 1'b0;
            s1_clear_q   <= 1'b0;
            s1_addr_q    <= {ADDR_WIDTH{1'b0}};
            s1_mag_q     <= ZERO;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= {ADDR_WIDTH{1'b0}};
            wb_data_q    <= ZERO;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= ZERO;
        end else begin
            busy_q       <= busy_d;
            sweep_addr_q <= sweep_addr_d;
            s1_valid_q   <= s1_valid_d;
            s1_rd_q      <= s1_rd_d;
            s1_clear_q   <= s1_clear_d;
            s1_addr_q    <= s1_addr_d;
            s1_mag_q     <= s1_mag_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign bus_if.rd_ack   = acc_rd_s;
    assign bus_if.rd_valid = rd_valid_q;
    assign bus_if.rd_data  = rd_data_q;
    assign bus_if.busy     = busy_q;
endmodule
